mac2fifod: RTL and testbench
============================

// Module: mac2fifod
// PURPOSE
//   Receive-side counterpart of fifod2mac. When the MAC reports a received UDP datagram, reads the
//   payload bytes out of the MAC receive buffer (udp_rx_addr/udp_rxd) and writes them, in order, into
//   the receive data FIFO (fifod write port). Runs on gmii_rxc; signals completion back to the MAC.
// PARAMETERS
//   ADDR_W      11     width of udp_rx_addr (MAC rx buffer depth 2^ADDR_W bytes)
//   LEN_W       12     width of data_len / internal byte counter
//   BASE_ADDR   0      buffer address of first payload byte
//   UDP_HDR     8      bytes subtracted from udp_rx_len to get payload length
//   MAX_LEN     1472   largest accepted payload (bytes)
// PORTS
//   clk          in   1       gmii_rxc; all logic on rising edge
//   rst          in   1       synchronous reset, active-low
//   fs           in   1       MAC: datagram ready; level, held high until fd seen
//   fd           out  1       done; level, high in DONE until fs falls
//   udp_rx_len   in   16      UDP length field (header+payload), valid while fs high
//   udp_rx_addr  out  ADDR_W  read address into MAC rx buffer
//   udp_rxd      in   8       read data, valid exactly 1 clk after udp_rx_addr
//   fifod_txen   out  1       FIFO write strobe
//   fifod_txd    out  8       FIFO write data
//   fifod_full   in   1       FIFO full; no write while high
//   data_len     out  LEN_W   payload length of current/last datagram
//   err          out  1       1-clk pulse: bad length, datagram dropped
// BEHAVIOUR
//   Reset (rst==0 at edge): state IDLE; fd, fifod_txen, err = 0; udp_rx_addr = BASE_ADDR;
//     fifod_txd, data_len = 0; skid register empty. Applies mid-datagram; bytes already written stay
//     in FIFO (no rollback).
//   States: IDLE -> LOAD -> READ -> DRAIN -> DONE -> IDLE; LOAD -> DONE on zero/bad length.
//   IDLE : wait fs==1 -> LOAD.
//   LOAD : len = udp_rx_len - UDP_HDR (16-bit). If udp_rx_len < UDP_HDR or len > MAX_LEN:
//          err=1 one clk, data_len=0, -> DONE. If len==0: data_len=0, no err, -> DONE.
//          Else data_len=len[LEN_W-1:0], rd_cnt=0, wr_cnt=0, addr=BASE_ADDR -> READ.
//   READ : each clk with room (fifod_full==0 and skid empty) issue one read: udp_rx_addr advances by 1,
//          rd_cnt++. Address wraps modulo 2^ADDR_W. After rd_cnt==len -> DRAIN.
//   Data path: byte returned 1 clk after its address. If fifod_full==0 it is written directly
//          (fifod_txen=1, fifod_txd=byte); if full, captured in 1-entry skid reg, written first once
//          full drops. No byte lost, duplicated or reordered. fifod_txen never high while fifod_full.
//   DRAIN: wait until wr_cnt==len and skid empty -> DONE.
//   DONE : fd=1; when fs==0 -> IDLE (fd=0 next clk). fs never restarts a datagram until seen low.
//   Latency: first fifod_txen 2 clks after LOAD entry with FIFO not full; throughput 1 byte/clk.
//   fs dropping before DONE is a MAC protocol error: ignored, datagram completes normally.
// TESTING
//   udp_rx_len=20, buffer[0..11]=0x00..0x0B, full=0 -> 12 writes 0x00..0x0B on consecutive clks,
//     data_len=12, fd high until fs low, err never high.
//   Same, fifod_full high 5 clks after 4th write -> identical byte sequence, no txen while full.
//   udp_rx_len=8 -> no writes, data_len=0, fd asserted, err=0.
//   udp_rx_len=5 and udp_rx_len=1489 -> err one-clk pulse, no writes, fd asserted.
//   BASE_ADDR=2040, len 16 -> addresses 2040..2047,0..7, bytes written in that order.
//   rst low after 6th write of 12 -> all outputs reset next clk; new fs -> full 12-byte datagram.

Source files
------------

// File: rtl/mac2fifod.sv
// mac2fifod: copies a received UDP payload from the MAC rx buffer
// into the receive data FIFO, then signals done back to the MAC.
module mac2fifod #(
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 12,
  parameter int BASE_ADDR = 0,
  parameter int UDP_HDR   = 8,
  parameter int MAX_LEN   = 1472
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [15:0]       udp_rx_len,
  output logic [ADDR_W-1:0] udp_rx_addr,
  input  logic [7:0]        udp_rxd,
  output logic              fifod_txen,
  output logic [7:0]        fifod_txd,
  input  logic              fifod_full,
  output logic [LEN_W-1:0]  data_len,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, READ, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]      len16;
  logic             len_bad;
  logic             len_zero;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] wr_cnt;
  logic             vld;
  logic             skid_v;
  logic [7:0]       skid;
  logic             issue;
  logic             drained;

  assign len16    = udp_rx_len - 16'(UDP_HDR);
  assign len_bad  = (udp_rx_len < 16'(UDP_HDR)) ||
                    (len16 > 16'(MAX_LEN));
  assign len_zero = (len16 == 16'd0);

  // A read is only launched when its byte is sure to have a home.
  assign issue = (state == READ) &&
                 (rd_cnt != data_len) &&
                 !fifod_full && !skid_v;

  assign drained = (wr_cnt == data_len) && !skid_v && !vld;

  // The skid byte is older than any in-flight byte, so it goes first.
  assign fifod_txen = (vld || skid_v) && !fifod_full;
  assign fifod_txd  = fifod_txen ? (skid_v ? skid : udp_rxd)
                                 : 8'h00;
  assign fd = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fs) state_nx = LOAD;
      LOAD:  state_nx = (len_bad || len_zero) ? DONE : READ;
      READ:  if (rd_cnt == data_len) state_nx = DRAIN;
      DRAIN: if (drained) state_nx = DONE;
      DONE:  if (!fs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Length capture, read address/count, write count and skid buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      udp_rx_addr <= ADDR_W'(BASE_ADDR);
      data_len    <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      err         <= 1'b0;
      vld         <= 1'b0;
      skid_v      <= 1'b0;
      skid        <= 8'h00;
    end else begin
      err <= 1'b0;
      vld <= issue;
      if (state == LOAD) begin
        rd_cnt      <= '0;
        wr_cnt      <= '0;
        udp_rx_addr <= ADDR_W'(BASE_ADDR);
        if (len_bad) begin
          err      <= 1'b1;
          data_len <= '0;
        end else begin
          data_len <= len16[LEN_W-1:0];
        end
      end
      if (issue) begin
        udp_rx_addr <= udp_rx_addr + ADDR_W'(1);
        rd_cnt      <= rd_cnt + LEN_W'(1);
      end
      if (fifod_txen) wr_cnt <= wr_cnt + LEN_W'(1);
      if (skid_v && !fifod_full) begin
        skid_v <= 1'b0;
      end else if (vld && fifod_full) begin
        skid_v <= 1'b1;
        skid   <= udp_rxd;
      end
    end
  end

endmodule

// File: tb/tb_mac2fifod.sv
// tb_mac2fifod: random and directed datagrams into two instances
// (base 0 and base 2040), checked against a queue-based payload model.
module tb_mac2fifod;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        full;
  logic [15:0] udp_rx_len;
  logic [10:0] addr[2];
  logic [7:0]  rxd[2];
  logic [7:0]  txd[2];
  logic        fd[2];
  logic        txen[2];
  logic        err[2];
  logic [11:0] dl[2];

  logic [7:0] mem[2048];
  logic [7:0] qe[2][$];
  logic [7:0] obs[2][$];
  int base[2] = '{0, 2040};
  int wcnt[2];
  int errcnt[2];
  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int first_cyc, last_cyc, start_cyc;
  int full_mode = 0;
  int hold = 0;
  bit trig = 0;

  always #5 clk = ~clk;

  mac2fifod #(.BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd[0]),
    .udp_rx_len(udp_rx_len), .udp_rx_addr(addr[0]),
    .udp_rxd(rxd[0]), .fifod_txen(txen[0]),
    .fifod_txd(txd[0]), .fifod_full(full),
    .data_len(dl[0]), .err(err[0])
  );

  mac2fifod #(.BASE_ADDR(2040)) u1 (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd[1]),
    .udp_rx_len(udp_rx_len), .udp_rx_addr(addr[1]),
    .udp_rxd(rxd[1]), .fifod_txen(txen[1]),
    .fifod_txd(txd[1]), .fifod_full(full),
    .data_len(dl[1]), .err(err[1])
  );

  // MAC rx buffer: registered read, data one clock after address.
  always @(posedge clk) begin
    rxd[0] <= mem[addr[0]];
    rxd[1] <= mem[addr[1]];
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of FIFO writes against the expected payload.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (txen[k]) begin
          chk("txen_while_full", int'(full), 0);
          if (qe[k].size() == 0) chk("unexpected_write", 1, 0);
          else chk("wr_byte", int'(txd[k]), int'(qe[k].pop_front()));
          wcnt[k]++;
          obs[k].push_back(txd[k]);
          if (k == 0) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
          end
        end
        if (err[k]) errcnt[k]++;
      end
    end
  end

  // FIFO full driver, changed just after the clock edge.
  always @(posedge clk) begin
    #1;
    case (full_mode)
      1: full = ($urandom_range(0, 3) == 0);
      2: begin
        if (hold > 0) begin
          full = 1'b1;
          hold--;
        end else begin
          full = 1'b0;
          if (!trig && wcnt[0] >= 4) begin
            trig = 1;
            full = 1'b1;
            hold = 4;
          end
        end
      end
      default: full = 1'b0;
    endcase
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_ident();
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
  endtask

  task automatic run(input int len, input int mode, input int rst_at);
    int n;
    bit bad;
    int t;
    bad = (len < 8) || (len - 8 > 1472);
    n = bad ? 0 : len - 8;
    for (int k = 0; k < 2; k++) begin
      qe[k].delete();
      obs[k].delete();
      wcnt[k] = 0;
      errcnt[k] = 0;
      for (int i = 0; i < n; i++)
        qe[k].push_back(mem[(base[k] + i) % 2048]);
    end
    first_cyc = -1;
    last_cyc = -1;
    trig = 0;
    hold = 0;
    full_mode = mode;
    full = 1'b0;
    udp_rx_len = 16'(len);
    fs = 1'b1;
    start_cyc = cyc;
    if (rst_at > 0) begin
      t = 0;
      while (wcnt[0] < rst_at && t < 200) begin
        tick();
        t++;
      end
      chk("reach_rst_point", wcnt[0], rst_at);
      rst = 1'b0;
      fs = 1'b0;
      full_mode = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("rst_fd", int'(fd[k]), 0);
        chk("rst_txen", int'(txen[k]), 0);
        chk("rst_txd", int'(txd[k]), 0);
        chk("rst_addr", int'(addr[k]), base[k]);
        chk("rst_dlen", int'(dl[k]), 0);
        chk("rst_err", int'(err[k]), 0);
        qe[k].delete();
      end
      rst = 1'b1;
      tick();
      tick();
      chk("writes_after_rst", wcnt[0], rst_at);
      return;
    end
    t = 0;
    while (!(fd[0] && fd[1]) && t < 4 * n + 60) begin
      tick();
      t++;
    end
    chk("fd_timeout", int'(fd[0] && fd[1]), 1);
    for (int k = 0; k < 2; k++) begin
      chk("write_count", wcnt[k], n);
      chk("data_len", int'(dl[k]), n);
      chk("err_cycles", errcnt[k], bad ? 1 : 0);
      chk("left_in_model", qe[k].size(), 0);
    end
    tick();
    tick();
    chk("fd_held", int'(fd[0] && fd[1]), 1);
    chk("no_late_write", wcnt[0], n);
    fs = 1'b0;
    tick();
    chk("fd_drop", int'(fd[0] || fd[1]), 0);
    tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst = 1'b0;
    fs = 1'b0;
    full = 1'b0;
    udp_rx_len = 16'd0;
    fill_ident();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("init_fd", int'(fd[k]), 0);
      chk("init_txen", int'(txen[k]), 0);
      chk("init_err", int'(err[k]), 0);
      chk("init_addr", int'(addr[k]), base[k]);
      chk("init_dlen", int'(dl[k]), 0);
    end
    rst = 1'b1;
    tick();

    // 12-byte datagram, no back-pressure: latency and order pinned.
    run(20, 0, -1);
    chk("first_latency", first_cyc - start_cyc, 3);
    chk("last_latency", last_cyc - start_cyc, 14);
    chk("u0_byte0", obs[0].size() > 0 ? int'(obs[0][0]) : -1, 0);
    chk("u0_byte11", obs[0].size() > 11 ? int'(obs[0][11]) : -1, 11);

    // Same datagram with five full cycles after the 4th write.
    run(20, 2, -1);
    chk("full_byte4", obs[0].size() > 4 ? int'(obs[0][4]) : -1, 4);
    chk("full_stall", last_cyc - start_cyc > 14 ? 1 : 0, 1);

    // Address wrap on the base-2040 instance.
    run(24, 0, -1);
    chk("wrap_byte0", obs[1].size() > 0 ? int'(obs[1][0]) : -1, 248);
    chk("wrap_byte7", obs[1].size() > 7 ? int'(obs[1][7]) : -1, 255);
    chk("wrap_byte8", obs[1].size() > 8 ? int'(obs[1][8]) : -1, 0);
    chk("wrap_byte15", obs[1].size() > 15 ? int'(obs[1][15]) : -1, 7);

    // Length corner cases.
    run(8, 0, -1);
    run(5, 0, -1);
    run(1489, 0, -1);
    run(1481, 0, -1);
    run(9, 1, -1);
    run(0, 0, -1);

    // Reset in the middle, then a clean datagram.
    run(20, 0, 6);
    run(20, 0, -1);
    chk("post_rst_byte0", obs[0].size() > 0 ? int'(obs[0][0]) : -1, 0);

    // Largest payload under random back-pressure.
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    run(1480, 1, -1);

    // Random datagrams.
    repeat (24) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 7);
      else len = $urandom_range(8, 72);
      run(len, $urandom_range(0, 1), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
